fifo_sc_ext: RTL and testbench

//  Single-clock parametrised FIFO, successor to the basic USB/UART buffer FIFO. Adds selectable

---
 rtl/fifo_sc_ext_pkg.sv | 35 +++
 rtl/fifo_sc_ext_if.sv | 33 +++
 rtl/fifo_sc_ext_sdp_ram.sv | 37 +++
 rtl/fifo_sc_ext.sv | 157 +++++++++++++++
 tb/tb_fifo_sc_ext.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_sc_ext_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the buffer FIFOs between the USB endpoint logic and
// the UART engines.
//   - FIFO_MODE_NORMAL / FIFO_MODE_SHOWAHEAD : read-mode selector values
//   - FIFO_AEMPTY_DEFAULT                    : default almost-empty level
//   - FIFO_AFULL_MARGIN                      : default almost-full distance
//                                              below DEPTH
//   - fifo_clog2()                           : ceil(log2(value)) for sizing
// -----------------------------------------------------------------------------
package fifo_pkg;

   typedef enum int {
      FIFO_MODE_NORMAL    = 0,
      FIFO_MODE_SHOWAHEAD = 1
   } fifo_mode_e;

   localparam int FIFO_AEMPTY_DEFAULT = 4;
   localparam int FIFO_AFULL_MARGIN   = 4;

   function automatic int fifo_clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      for (int i = 0; i < 32; i++) begin
         if (v > 0) begin
            result = result + 1;
            v      = v >> 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_sc_ext_if.sv
// -----------------------------------------------------------------------------
// fifo_sc_ext_if
// Handshake and status bundle of the single-clock FIFO.
//   master : producer/consumer side (drives data, wrreq, rdreq, clr_err)
//   slave  : FIFO side (drives q, flags, usedw, error flags)
// -----------------------------------------------------------------------------
interface fifo_sc_ext_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] data;
   logic                  wrreq;
   logic                  rdreq;
   logic                  clr_err;
   logic [DATA_WIDTH-1:0] q;
   logic                  empty;
   logic                  full;
   logic                  almost_empty;
   logic                  almost_full;
   logic [ADDR_WIDTH:0]   usedw;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output data, wrreq, rdreq, clr_err,
      input  q, empty, full, almost_empty, almost_full, usedw, overflow, underflow
   );

   modport slave (
      input  data, wrreq, rdreq, clr_err,
      output q, empty, full, almost_empty, almost_full, usedw, overflow, underflow
   );
endinterface

// File: rtl/fifo_sc_ext_sdp_ram.sv
// -----------------------------------------------------------------------------
// fifo_sdp_ram
// Simple dual-port RAM, DEPTH x DATA_WIDTH, synchronous write, registered read,
// no reset (contents survive a FIFO reset).
//   clk        : clock
//   i_wr_en    : write enable
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_addr  : read address, sampled every edge
//   o_rd_data  : registered read data (old contents on same-address write)
// -----------------------------------------------------------------------------
module fifo_sdp_ram
   import fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int DEPTH      = 256,
   localparam int AW         = fifo_clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  i_wr_en,
   input  logic [AW-1:0]         i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [AW-1:0]         i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;
endmodule

// File: rtl/fifo_sc_ext.sv
// -----------------------------------------------------------------------------
// fifo_sc_ext
// Single-clock FIFO with normal or show-ahead (FWFT) read mode, programmable
// almost flags, full-range occupancy count, pass-through when full and sticky
// overflow/underflow flags.
//   clock   : single clock, rising edge
//   sclr_n  : synchronous active-low reset
//   bus     : fifo_sc_ext_if.slave (data/wrreq/rdreq/clr_err in;
//             q/empty/full/almost_empty/almost_full/usedw/overflow/underflow out)
// -----------------------------------------------------------------------------
module fifo_sc_ext
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 8,
   parameter int SHOWAHEAD     = FIFO_MODE_NORMAL,
   parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - FIFO_AFULL_MARGIN,
   parameter int AEMPTY_THRESH = FIFO_AEMPTY_DEFAULT
) (
   input  logic         clock,
   input  logic         sclr_n,
   fifo_sc_ext_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int UW    = ADDR_WIDTH + 1;

   localparam logic [UW-1:0] C_DEPTH  = UW'(DEPTH);
   localparam logic [UW-1:0] C_AFULL  = UW'(AFULL_THRESH);
   localparam logic [UW-1:0] C_AEMPTY = UW'(AEMPTY_THRESH);
   localparam logic [UW-1:0] C_ONE    = UW'(1);

   generate
      if (!(AEMPTY_THRESH >= 0 && AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH)) begin : g_bad_thresh
         $error("fifo_sc_ext: thresholds must satisfy 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
      end
      if (SHOWAHEAD != FIFO_MODE_NORMAL && SHOWAHEAD != FIFO_MODE_SHOWAHEAD) begin : g_bad_mode
         $error("fifo_sc_ext: SHOWAHEAD must be 0 or 1");
      end
   endgenerate

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH-1:0] w_rd_addr;
   logic [UW-1:0]         r_usedw;
   logic [UW-1:0]         w_usedw_next;
   logic [DATA_WIDTH-1:0] r_q;
   logic [DATA_WIDTH-1:0] r_fwd_data;
   logic [DATA_WIDTH-1:0] w_ram_q;
   logic [DATA_WIDTH-1:0] w_mem_head;
   logic                  r_fwd_hit;
   logic                  r_overflow;
   logic                  r_underflow;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_rd_ok;
   logic                  w_wr_ok;
   logic                  w_mem_we;
   logic                  w_mem_re;
   logic                  w_ram_we;
   logic                  w_q_load;
   logic                  w_q_from_data;

   // Flags come only from the registered count.
   assign w_empty = (r_usedw == '0);
   assign w_full  = (r_usedw == C_DEPTH);

   assign w_rd_ok = bus.rdreq & ~w_empty;
   assign w_wr_ok = bus.wrreq & (~w_full | w_rd_ok);

   always_comb begin
      w_usedw_next = r_usedw;
      if (w_wr_ok && !w_rd_ok) begin
         w_usedw_next = r_usedw + C_ONE;
      end else if (!w_wr_ok && w_rd_ok) begin
         w_usedw_next = r_usedw - C_ONE;
      end
   end

   generate
      if (SHOWAHEAD == FIFO_MODE_SHOWAHEAD) begin : g_fwft
         // The output register holds the head word, so the RAM only stores
         // the words behind it. A write lands directly in q when the FIFO is
         // empty, or when the single stored word is popped in the same cycle.
         logic w_bypass;
         assign w_bypass      = w_wr_ok & (w_empty | ((r_usedw == C_ONE) & w_rd_ok));
         assign w_mem_we      = w_wr_ok & ~w_bypass;
         assign w_mem_re      = w_rd_ok & (r_usedw != C_ONE);
         assign w_q_load      = w_bypass | w_mem_re;
         assign w_q_from_data = w_bypass;
      end else begin : g_normal
         assign w_mem_we      = w_wr_ok;
         assign w_mem_re      = w_rd_ok;
         assign w_q_load      = w_rd_ok;
         assign w_q_from_data = 1'b0;
      end
   endgenerate

   // The RAM continuously prefetches the word at the read pointer as it will
   // be after this edge, so the current head is available without waiting for
   // a RAM read cycle.
   assign w_rd_addr = sclr_n ? (r_rd_ptr + ADDR_WIDTH'(w_mem_re)) : '0;
   assign w_ram_we  = sclr_n & w_mem_we;

   // A write landing on the address being prefetched in the same edge would
   // leave the RAM output stale for one cycle; the captured write data covers it.
   assign w_mem_head = r_fwd_hit ? r_fwd_data : w_ram_q;

   fifo_sdp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk        (clock),
      .i_wr_en    (w_ram_we),
      .i_wr_addr  (r_wr_ptr),
      .i_wr_data  (bus.data),
      .i_rd_addr  (w_rd_addr),
      .o_rd_data  (w_ram_q)
   );

   always_ff @(posedge clock) begin
      if (!sclr_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_usedw     <= '0;
         r_q         <= '0;
         r_fwd_hit   <= 1'b0;
         r_fwd_data  <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_mem_we) begin
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         end
         if (w_mem_re) begin
            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         end
         r_usedw <= w_usedw_next;
         if (w_q_load) begin
            r_q <= w_q_from_data ? bus.data : w_mem_head;
         end
         r_fwd_hit  <= w_ram_we & (r_wr_ptr == w_rd_addr);
         r_fwd_data <= bus.data;
         // A new error event wins over a coincident clear.
         r_overflow  <= (bus.wrreq & w_full & ~w_rd_ok) | (r_overflow & ~bus.clr_err);
         r_underflow <= (bus.rdreq & w_empty) | (r_underflow & ~bus.clr_err);
      end
   end

   assign bus.q            = r_q;
   assign bus.usedw        = r_usedw;
   assign bus.empty        = w_empty;
   assign bus.full         = w_full;
   assign bus.almost_empty = (r_usedw <= C_AEMPTY);
   assign bus.almost_full  = (r_usedw >= C_AFULL);
   assign bus.overflow     = r_overflow;
   assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_sc_ext.sv
// -----------------------------------------------------------------------------
// tb_fifo_sc_ext
// Two 8-deep FIFOs (normal and show-ahead) with almost_full at 4 and
// almost_empty at 1, exercised with directed sequences and a random run
// against a queue model.
// -----------------------------------------------------------------------------
module tb_fifo_sc_ext;
   logic clk = 1'b0;
   logic sclr_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   fifo_sc_ext_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) if_n ();
   fifo_sc_ext_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) if_f ();

   fifo_sc_ext #(
      .DATA_WIDTH(8), .ADDR_WIDTH(3), .SHOWAHEAD(0), .AFULL_THRESH(4), .AEMPTY_THRESH(1)
   ) u_norm (
      .clock (clk),
      .sclr_n(sclr_n),
      .bus   (if_n.slave)
   );

   fifo_sc_ext #(
      .DATA_WIDTH(8), .ADDR_WIDTH(3), .SHOWAHEAD(1), .AFULL_THRESH(4), .AEMPTY_THRESH(1)
   ) u_fwft (
      .clock (clk),
      .sclr_n(sclr_n),
      .bus   (if_f.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_n(input logic wr, input logic rd, input logic clr, input logic [7:0] d);
      if_n.wrreq = wr; if_n.rdreq = rd; if_n.clr_err = clr; if_n.data = d;
   endtask

   task automatic set_f(input logic wr, input logic rd, input logic clr, input logic [7:0] d);
      if_f.wrreq = wr; if_f.rdreq = rd; if_f.clr_err = clr; if_f.data = d;
   endtask

   // {empty, almost_empty, full, almost_full, overflow, underflow}
   function automatic logic [5:0] flags_n();
      return {if_n.empty, if_n.almost_empty, if_n.full, if_n.almost_full, if_n.overflow, if_n.underflow};
   endfunction

   function automatic logic [5:0] flags_f();
      return {if_f.empty, if_f.almost_empty, if_f.full, if_f.almost_full, if_f.overflow, if_f.underflow};
   endfunction

   task automatic test_reset();
      sclr_n = 1'b0;
      set_n(1'b1, 1'b1, 1'b0, 8'hFF);
      set_f(1'b1, 1'b1, 1'b0, 8'hFF);
      step(); step();
      n_checks++; if (flags_n() !== 6'b110000) begin n_fail++; $display("FAIL reset_flags_n: got %b expected %b", flags_n(), 6'b110000); end
      n_checks++; if (if_n.usedw !== 4'd0) begin n_fail++; $display("FAIL reset_usedw_n: got %0d expected 0", if_n.usedw); end
      n_checks++; if (if_n.q !== 8'h00) begin n_fail++; $display("FAIL reset_q_n: got %0h expected 0", if_n.q); end
      n_checks++; if (flags_f() !== 6'b110000) begin n_fail++; $display("FAIL reset_flags_f: got %b expected %b", flags_f(), 6'b110000); end
      n_checks++; if (if_f.usedw !== 4'd0) begin n_fail++; $display("FAIL reset_usedw_f: got %0d expected 0", if_f.usedw); end
      n_checks++; if (if_f.q !== 8'h00) begin n_fail++; $display("FAIL reset_q_f: got %0h expected 0", if_f.q); end
      sclr_n = 1'b1;
      set_n(1'b0, 1'b0, 1'b0, 8'h00);
      set_f(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_fill_drain();
      logic [5:0] exp_fl;
      logic [7:0] exp_q;
      for (int i = 0; i < 8; i++) begin
         set_n(1'b1, 1'b0, 1'b0, 8'(i));
         step();
         exp_fl = {1'b0, (i + 1) <= 1, (i + 1) == 8, (i + 1) >= 4, 2'b00};
         n_checks++; if (if_n.usedw !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_usedw[%0d]: got %0d expected %0d", i, if_n.usedw, i + 1); end
         n_checks++; if (flags_n() !== exp_fl) begin n_fail++; $display("FAIL fill_flags[%0d]: got %b expected %b", i, flags_n(), exp_fl); end
      end
      set_n(1'b1, 1'b0, 1'b0, 8'h99);
      step();
      n_checks++; if (flags_n() !== 6'b001110) begin n_fail++; $display("FAIL overflow_flags: got %b expected %b", flags_n(), 6'b001110); end
      n_checks++; if (if_n.usedw !== 4'd8) begin n_fail++; $display("FAIL overflow_usedw: got %0d expected 8", if_n.usedw); end
      set_n(1'b0, 1'b0, 1'b1, 8'h00);
      step();
      n_checks++; if (if_n.overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clear: got %b expected 0", if_n.overflow); end
      for (int i = 0; i < 8; i++) begin
         set_n(1'b0, 1'b1, 1'b0, 8'h00);
         step();
         exp_q = 8'(i);
         n_checks++; if (if_n.q !== exp_q) begin n_fail++; $display("FAIL drain_q[%0d]: got %0h expected %0h", i, if_n.q, exp_q); end
         n_checks++; if (if_n.usedw !== 4'(7 - i)) begin n_fail++; $display("FAIL drain_usedw[%0d]: got %0d expected %0d", i, if_n.usedw, 7 - i); end
      end
      set_n(1'b0, 1'b0, 1'b0, 8'h00);
      n_checks++; if (flags_n() !== 6'b110000) begin n_fail++; $display("FAIL drain_flags: got %b expected %b", flags_n(), 6'b110000); end
   endtask

   task automatic test_pass_through();
      logic [7:0] exp_q;
      for (int i = 0; i < 8; i++) begin
         set_n(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
         step();
      end
      set_n(1'b1, 1'b1, 1'b0, 8'hA5);
      step();
      n_checks++; if (if_n.q !== 8'h10) begin n_fail++; $display("FAIL pass_q: got %0h expected 10", if_n.q); end
      n_checks++; if (if_n.usedw !== 4'd8) begin n_fail++; $display("FAIL pass_usedw: got %0d expected 8", if_n.usedw); end
      n_checks++; if (if_n.overflow !== 1'b0) begin n_fail++; $display("FAIL pass_overflow: got %b expected 0", if_n.overflow); end
      for (int i = 0; i < 8; i++) begin
         set_n(1'b0, 1'b1, 1'b0, 8'h00);
         step();
         exp_q = (i < 7) ? 8'(8'h11 + i) : 8'hA5;
         n_checks++; if (if_n.q !== exp_q) begin n_fail++; $display("FAIL pass_drain_q[%0d]: got %0h expected %0h", i, if_n.q, exp_q); end
      end
      set_n(1'b0, 1'b0, 1'b0, 8'h00);
      n_checks++; if (if_n.empty !== 1'b1) begin n_fail++; $display("FAIL pass_empty: got %b expected 1", if_n.empty); end
   endtask

   task automatic test_underflow();
      set_n(1'b0, 1'b1, 1'b0, 8'h00);
      step();
      n_checks++; if (if_n.underflow !== 1'b1) begin n_fail++; $display("FAIL udf_set: got %b expected 1", if_n.underflow); end
      n_checks++; if (if_n.usedw !== 4'd0) begin n_fail++; $display("FAIL udf_usedw: got %0d expected 0", if_n.usedw); end
      set_n(1'b0, 1'b0, 1'b1, 8'h00);
      step();
      n_checks++; if (if_n.underflow !== 1'b0) begin n_fail++; $display("FAIL udf_clear: got %b expected 0", if_n.underflow); end
      set_n(1'b0, 1'b1, 1'b1, 8'h00);
      step();
      n_checks++; if (if_n.underflow !== 1'b1) begin n_fail++; $display("FAIL udf_clr_coincident: got %b expected 1", if_n.underflow); end
      set_n(1'b0, 1'b0, 1'b1, 8'h00);
      step();
      set_n(1'b1, 1'b1, 1'b0, 8'h5A);
      step();
      n_checks++; if (if_n.underflow !== 1'b1) begin n_fail++; $display("FAIL udf_wr_rd_empty_flag: got %b expected 1", if_n.underflow); end
      n_checks++; if (if_n.usedw !== 4'd1) begin n_fail++; $display("FAIL udf_wr_rd_empty_usedw: got %0d expected 1", if_n.usedw); end
      set_n(1'b0, 1'b1, 1'b1, 8'h00);
      step();
      n_checks++; if (if_n.q !== 8'h5A) begin n_fail++; $display("FAIL udf_readback_q: got %0h expected 5a", if_n.q); end
      n_checks++; if (if_n.underflow !== 1'b0) begin n_fail++; $display("FAIL udf_readback_flag: got %b expected 0", if_n.underflow); end
      set_n(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_fwft();
      logic [7:0] exp_q;
      set_f(1'b1, 1'b0, 1'b0, 8'h3C);
      step();
      n_checks++; if (if_f.q !== 8'h3C) begin n_fail++; $display("FAIL fwft_first_q: got %0h expected 3c", if_f.q); end
      n_checks++; if (if_f.empty !== 1'b0) begin n_fail++; $display("FAIL fwft_first_empty: got %b expected 0", if_f.empty); end
      for (int i = 1; i < 5; i++) begin
         set_f(1'b1, 1'b0, 1'b0, 8'(8'h3C + i));
         step();
      end
      n_checks++; if (if_f.usedw !== 4'd5) begin n_fail++; $display("FAIL fwft_usedw: got %0d expected 5", if_f.usedw); end
      for (int i = 0; i < 5; i++) begin
         exp_q = 8'(8'h3C + i);
         n_checks++; if (if_f.q !== exp_q) begin n_fail++; $display("FAIL fwft_stream_q[%0d]: got %0h expected %0h", i, if_f.q, exp_q); end
         set_f(1'b0, 1'b1, 1'b0, 8'h00);
         step();
      end
      n_checks++; if (if_f.empty !== 1'b1) begin n_fail++; $display("FAIL fwft_drained_empty: got %b expected 1", if_f.empty); end
      set_f(1'b1, 1'b0, 1'b0, 8'h77);
      step();
      set_f(1'b1, 1'b1, 1'b0, 8'h88);
      step();
      n_checks++; if (if_f.q !== 8'h88) begin n_fail++; $display("FAIL fwft_wr_rd_one_q: got %0h expected 88", if_f.q); end
      n_checks++; if (if_f.usedw !== 4'd1) begin n_fail++; $display("FAIL fwft_wr_rd_one_usedw: got %0d expected 1", if_f.usedw); end
      set_f(1'b0, 1'b1, 1'b0, 8'h00);
      step();
      set_f(1'b0, 1'b0, 1'b0, 8'h00);
      n_checks++; if (if_f.empty !== 1'b1) begin n_fail++; $display("FAIL fwft_final_empty: got %b expected 1", if_f.empty); end
   endtask

   task automatic test_random();
      logic [7:0] sq[$];
      logic [7:0] eq_n;
      logic [7:0] exp_qf;
      logic [7:0] d;
      logic [5:0] exp_fl;
      logic       ovf, udf, wr, rd, clr, rst, rd_ok, wr_ok, full, emp, heavy;
      int         sz;
      sclr_n = 1'b0;
      set_n(1'b0, 1'b0, 1'b0, 8'h00);
      set_f(1'b0, 1'b0, 1'b0, 8'h00);
      step();
      sclr_n = 1'b1;
      eq_n = 8'h00; ovf = 1'b0; udf = 1'b0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         heavy = (((cyc / 64) % 2) == 0);
         wr  = heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         rd  = heavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 15) == 0);
         rst = (cyc == 500);
         d   = 8'($urandom);
         sclr_n = ~rst;
         set_n(wr, rd, clr, d);
         set_f(wr, rd, clr, d);
         step();
         if (rst) begin
            sq.delete();
            eq_n = 8'h00; ovf = 1'b0; udf = 1'b0;
         end else begin
            full  = (sq.size() == 8);
            emp   = (sq.size() == 0);
            rd_ok = rd && !emp;
            wr_ok = wr && (!full || rd_ok);
            ovf   = (wr && full && !rd_ok) || (ovf && !clr);
            udf   = (rd && emp) || (udf && !clr);
            if (rd_ok) eq_n = sq.pop_front();
            if (wr_ok) sq.push_back(d);
         end
         sz     = sq.size();
         exp_fl = {sz == 0, sz <= 1, sz == 8, sz >= 4, ovf, udf};
         n_checks++; if (if_n.usedw !== 4'(sz)) begin n_fail++; $display("FAIL rand_usedw_n[%0d]: got %0d expected %0d", cyc, if_n.usedw, sz); end
         n_checks++; if (flags_n() !== exp_fl) begin n_fail++; $display("FAIL rand_flags_n[%0d]: got %b expected %b", cyc, flags_n(), exp_fl); end
         n_checks++; if (if_n.q !== eq_n) begin n_fail++; $display("FAIL rand_q_n[%0d]: got %0h expected %0h", cyc, if_n.q, eq_n); end
         n_checks++; if (if_f.usedw !== 4'(sz)) begin n_fail++; $display("FAIL rand_usedw_f[%0d]: got %0d expected %0d", cyc, if_f.usedw, sz); end
         n_checks++; if (flags_f() !== exp_fl) begin n_fail++; $display("FAIL rand_flags_f[%0d]: got %b expected %b", cyc, flags_f(), exp_fl); end
         if (sz > 0 || rst) begin
            exp_qf = rst ? 8'h00 : sq[0];
            n_checks++; if (if_f.q !== exp_qf) begin n_fail++; $display("FAIL rand_q_f[%0d]: got %0h expected %0h", cyc, if_f.q, exp_qf); end
         end
      end
      sclr_n = 1'b1;
      set_n(1'b0, 1'b0, 1'b0, 8'h00);
      set_f(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      sclr_n = 1'b0;
      set_n(1'b0, 1'b0, 1'b0, 8'h00);
      set_f(1'b0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      test_reset();
      test_fill_drain();
      test_pass_through();
      test_underflow();
      test_fwft();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
